zorro_slave_dtack_ctrl: RTL

- Multi-region Zorro slave DTACK generator; successor to the single-region SCSI DTACK logic.
- Serves NUM_REGIONS chip-select regions (SCSI, ROM, registers, ...). Each region terminates either after a programmable fixed wait-state count or on its external active-low ack.
- A watchdog forces termination if an external ack never arrives.
- Sits between the Zorro address decode and the bus DTACK driver.

---
 rtl/zorro_slave_pkg.sv | 18 +
 rtl/zorro_slave_dtack_ctrl_region_prio_enc.sv | 26 ++
 rtl/zorro_slave_dtack_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/zorro_slave_pkg.sv
// Shared types and constants for the Zorro slave DTACK controller and its decode helpers.
package zorro_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DTACK = 2'd2
    } state_t;

    localparam logic MODE_FIXED   = 1'b0;
    localparam logic MODE_EXT_ACK = 1'b1;

    // Index width for an n-entry select vector; a single region still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zorro_slave_dtack_ctrl_region_prio_enc.sv
// Lowest-index-first one-hot to index encoder with a valid flag; shared with the address decode.
module region_prio_enc
    import zorro_slave_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      valid
);

    localparam int W = idx_width(N);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zorro_slave_dtack_ctrl.sv
// Multi-region Zorro slave DTACK generator with fixed wait states or external ack plus watchdog.
// Optional macro DTACK_TIMEOUT_BERR_EN: watchdog expiry raises slave_berr instead of slave_dtack.
module zorro_slave_dtack_ctrl
    import zorro_slave_pkg::*;
#(
    parameter int NUM_REGIONS    = 4,
    parameter int WAIT_W         = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              CLK,
    input  logic                              RESET_n,
    input  logic                              FCS_n,
    input  logic                              configured,
    input  logic                              slave_cycle,
    input  logic [NUM_REGIONS-1:0]            region_sel,
    input  logic [NUM_REGIONS-1:0]            ack_mode,
    input  logic [NUM_REGIONS*WAIT_W-1:0]     wait_cnt,
    input  logic [NUM_REGIONS-1:0]            ext_ack_n,
    output logic                              slave_dtack,
    output logic                              busy,
    output logic [idx_width(NUM_REGIONS)-1:0] active_region,
`ifdef DTACK_TIMEOUT_BERR_EN
    output logic                              slave_berr,
`endif
    output logic                              timeout_err
);

    localparam int IDX_W = idx_width(NUM_REGIONS);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic               mode;
    logic [WAIT_W-1:0]  wait_ctr;
    logic [TMO_W-1:0]   tmo_ctr;
    logic [IDX_W-1:0]   hit_idx;
    logic               hit_valid;

    region_prio_enc #(
        .N (NUM_REGIONS)
    ) u_prio (
        .req   (region_sel),
        .idx   (hit_idx),
        .valid (hit_valid)
    );

    // Region, mode and wait count are captured at the start edge so later decode changes cannot disturb a cycle.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= IDLE;
            slave_dtack   <= 1'b0;
            busy          <= 1'b0;
            active_region <= '0;
            timeout_err   <= 1'b0;
            mode          <= MODE_FIXED;
            wait_ctr      <= '0;
            tmo_ctr       <= '0;
`ifdef DTACK_TIMEOUT_BERR_EN
            slave_berr    <= 1'b0;
`endif
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!FCS_n && configured && slave_cycle && hit_valid) begin
                        state         <= WAIT;
                        busy          <= 1'b1;
                        active_region <= hit_idx;
                        mode          <= ack_mode[hit_idx];
                        wait_ctr      <= wait_cnt[int'(hit_idx) * WAIT_W +: WAIT_W];
                        tmo_ctr       <= '0;
                    end
                end
                WAIT: begin
                    if (FCS_n) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (mode == MODE_FIXED) begin
                        if (wait_ctr == '0) begin
                            state       <= DTACK;
                            slave_dtack <= 1'b1;
                        end else begin
                            wait_ctr <= wait_ctr - 1'b1;
                        end
                    end else if (mode == MODE_EXT_ACK) begin
                        // A real ack on the watchdog edge still counts as a normal termination.
                        if (!ext_ack_n[active_region]) begin
                            state       <= DTACK;
                            slave_dtack <= 1'b1;
                        end else if (tmo_ctr == TMO_LAST) begin
                            state       <= DTACK;
                            timeout_err <= 1'b1;
`ifdef DTACK_TIMEOUT_BERR_EN
                            slave_berr  <= 1'b1;
`else
                            slave_dtack <= 1'b1;
`endif
                        end else begin
                            tmo_ctr <= tmo_ctr + 1'b1;
                        end
                    end
                end
                DTACK: begin
                    if (FCS_n) begin
                        state       <= IDLE;
                        slave_dtack <= 1'b0;
                        busy        <= 1'b0;
`ifdef DTACK_TIMEOUT_BERR_EN
                        slave_berr  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
